// File: rtl/l2tlb_ctx.sv
// l2tlb_ctx: fully associative L2 TLB tagged by {context index, VPN} with an NCTX-slot SBPTR table.
// Define L2TLB_PERF_CNT_EN to add saturating perf_hits / perf_misses counters.
module l2tlb_ctx #(
   parameter int unsigned VPN_W   = 36,
   parameter int unsigned PPN_W   = 28,
   parameter int unsigned SBPTR_W = 20,
   parameter int unsigned ID_W    = 6,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned NCTX    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_retry,
   input  logic [SBPTR_W-1:0] req_sbptr,
   input  logic [VPN_W-1:0]   req_vpn,
   input  logic [ID_W-1:0]    req_id,
   output logic               resp_valid,
   input  logic               resp_retry,
   output logic [ID_W-1:0]    resp_id,
   output logic [PPN_W-1:0]   resp_ppn,
   output logic               resp_fault,
   output logic               walk_valid,
   input  logic               walk_retry,
   output logic [SBPTR_W-1:0] walk_sbptr,
   output logic [VPN_W-1:0]   walk_vpn,
   input  logic               fill_valid,
   output logic               fill_retry,
   input  logic [PPN_W-1:0]   fill_ppn,
   input  logic               fill_fault,
   output logic               snoop_valid,
   input  logic               snoop_retry,
   output logic [SBPTR_W-1:0] snoop_sbptr
`ifdef L2TLB_PERF_CNT_EN
   ,
   output logic [31:0]        perf_hits,
   output logic [31:0]        perf_misses
`endif
);
   localparam int unsigned CTX_W = $clog2(NCTX);
   localparam int unsigned ENT_W = $clog2(ENTRIES);

   typedef enum logic [2:0] {IDLE, RESP, WALK, WAIT_FILL, SNOOP} state_t;
   state_t state_q, state_d;

   logic [ENTRIES-1:0] ent_valid_q, ent_valid_d;
   logic [CTX_W-1:0]   ent_ctx_q [ENTRIES];
   logic [CTX_W-1:0]   ent_ctx_d [ENTRIES];
   logic [VPN_W-1:0]   ent_vpn_q [ENTRIES];
   logic [VPN_W-1:0]   ent_vpn_d [ENTRIES];
   logic [PPN_W-1:0]   ent_ppn_q [ENTRIES];
   logic [PPN_W-1:0]   ent_ppn_d [ENTRIES];

   logic [NCTX-1:0]    ctx_valid_q, ctx_valid_d;
   logic [SBPTR_W-1:0] ctx_sbptr_q [NCTX];
   logic [SBPTR_W-1:0] ctx_sbptr_d [NCTX];

   logic [CTX_W-1:0]   ctx_rr_q, ctx_rr_d, cur_ctx_q, cur_ctx_d;
   logic [ENT_W-1:0]   ent_rr_q, ent_rr_d;
   logic [SBPTR_W-1:0] sbptr_q, sbptr_d, snoop_sbptr_q, snoop_sbptr_d;
   logic [VPN_W-1:0]   vpn_q, vpn_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [PPN_W-1:0]   resp_ppn_q, resp_ppn_d;
   logic               resp_fault_q, resp_fault_d;

   logic               ctx_hit, ctx_free, ent_hit, ent_free;
   logic [CTX_W-1:0]   ctx_hit_idx, ctx_free_idx;
   logic [ENT_W-1:0]   ent_free_idx, ent_ins_idx;
   logic [PPN_W-1:0]   ent_hit_ppn;

   // Context match uses the live request; entry match keys on the matched slot index.
   always_comb begin
      ctx_hit      = 1'b0;
      ctx_hit_idx  = '0;
      ctx_free     = 1'b0;
      ctx_free_idx = '0;
      for (int unsigned i = 0; i < NCTX; i++) begin
         if (ctx_valid_q[i] && (ctx_sbptr_q[i] == req_sbptr)) begin
            ctx_hit     = 1'b1;
            ctx_hit_idx = CTX_W'(i);
         end
         if (!ctx_valid_q[i] && !ctx_free) begin
            ctx_free     = 1'b1;
            ctx_free_idx = CTX_W'(i);
         end
      end
      ent_hit      = 1'b0;
      ent_hit_ppn  = '0;
      ent_free     = 1'b0;
      ent_free_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (ent_valid_q[i] && (ent_ctx_q[i] == ctx_hit_idx) && (ent_vpn_q[i] == req_vpn)) begin
            ent_hit     = 1'b1;
            ent_hit_ppn = ent_ppn_q[i];
         end
         if (!ent_valid_q[i] && !ent_free) begin
            ent_free     = 1'b1;
            ent_free_idx = ENT_W'(i);
         end
      end
      ent_ins_idx = ent_free ? ent_free_idx : ent_rr_q;
   end

   always_comb begin
      state_d       = state_q;
      ent_valid_d   = ent_valid_q;
      ent_ctx_d     = ent_ctx_q;
      ent_vpn_d     = ent_vpn_q;
      ent_ppn_d     = ent_ppn_q;
      ctx_valid_d   = ctx_valid_q;
      ctx_sbptr_d   = ctx_sbptr_q;
      ctx_rr_d      = ctx_rr_q;
      cur_ctx_d     = cur_ctx_q;
      ent_rr_d      = ent_rr_q;
      sbptr_d       = sbptr_q;
      vpn_d         = vpn_q;
      id_d          = id_q;
      resp_ppn_d    = resp_ppn_q;
      resp_fault_d  = resp_fault_q;
      snoop_sbptr_d = snoop_sbptr_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               sbptr_d = req_sbptr;
               vpn_d   = req_vpn;
               id_d    = req_id;
               if (ctx_hit) begin
                  cur_ctx_d = ctx_hit_idx;
                  if (ent_hit) begin
                     resp_ppn_d   = ent_hit_ppn;
                     resp_fault_d = 1'b0;
                     state_d      = RESP;
                  end else begin
                     state_d = WALK;
                  end
               end else if (ctx_free) begin
                  ctx_valid_d[ctx_free_idx] = 1'b1;
                  ctx_sbptr_d[ctx_free_idx] = req_sbptr;
                  cur_ctx_d                 = ctx_free_idx;
                  state_d                   = WALK;
               end else begin
                  // Evict the round-robin slot: its entries go and the DCTLB is told.
                  for (int unsigned i = 0; i < ENTRIES; i++) begin
                     if (ent_ctx_q[i] == ctx_rr_q) ent_valid_d[i] = 1'b0;
                  end
                  snoop_sbptr_d         = ctx_sbptr_q[ctx_rr_q];
                  ctx_sbptr_d[ctx_rr_q] = req_sbptr;
                  cur_ctx_d             = ctx_rr_q;
                  ctx_rr_d              = ctx_rr_q + CTX_W'(1);
                  state_d               = SNOOP;
               end
            end
         end
         SNOOP: if (!snoop_retry) state_d = WALK;
         WALK:  if (!walk_retry) state_d = WAIT_FILL;
         WAIT_FILL: begin
            if (fill_valid) begin
               resp_ppn_d   = fill_ppn;
               resp_fault_d = fill_fault;
               state_d      = RESP;
               if (!fill_fault) begin
                  ent_valid_d[ent_ins_idx] = 1'b1;
                  ent_ctx_d[ent_ins_idx]   = cur_ctx_q;
                  ent_vpn_d[ent_ins_idx]   = vpn_q;
                  ent_ppn_d[ent_ins_idx]   = fill_ppn;
                  if (!ent_free) begin
                     ent_rr_d = (ent_rr_q == ENT_W'(ENTRIES - 1)) ? '0 : ent_rr_q + ENT_W'(1);
                  end
               end
            end
         end
         RESP:    if (!resp_retry) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         ent_valid_q   <= '0;
         ctx_valid_q   <= '0;
         ctx_rr_q      <= '0;
         ent_rr_q      <= '0;
         cur_ctx_q     <= '0;
         sbptr_q       <= '0;
         vpn_q         <= '0;
         id_q          <= '0;
         resp_ppn_q    <= '0;
         resp_fault_q  <= 1'b0;
         snoop_sbptr_q <= '0;
      end else begin
         state_q       <= state_d;
         ent_valid_q   <= ent_valid_d;
         ctx_valid_q   <= ctx_valid_d;
         ctx_rr_q      <= ctx_rr_d;
         ent_rr_q      <= ent_rr_d;
         cur_ctx_q     <= cur_ctx_d;
         sbptr_q       <= sbptr_d;
         vpn_q         <= vpn_d;
         id_q          <= id_d;
         resp_ppn_q    <= resp_ppn_d;
         resp_fault_q  <= resp_fault_d;
         snoop_sbptr_q <= snoop_sbptr_d;
      end
   end

   // Payload arrays are qualified by valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      ent_ctx_q   <= ent_ctx_d;
      ent_vpn_q   <= ent_vpn_d;
      ent_ppn_q   <= ent_ppn_d;
      ctx_sbptr_q <= ctx_sbptr_d;
   end

   assign req_retry   = !reset || (state_q != IDLE);
   assign fill_retry  = !reset || (state_q != WAIT_FILL);
   assign resp_valid  = (state_q == RESP);
   assign walk_valid  = (state_q == WALK);
   assign snoop_valid = (state_q == SNOOP);
   assign resp_id     = id_q;
   assign resp_ppn    = resp_ppn_q;
   assign resp_fault  = resp_fault_q;
   assign walk_sbptr  = sbptr_q;
   assign walk_vpn    = vpn_q;
   assign snoop_sbptr = snoop_sbptr_q;

`ifdef L2TLB_PERF_CNT_EN
   logic [31:0] hits_q, hits_d, misses_q, misses_d;

   always_comb begin
      hits_d   = hits_q;
      misses_d = misses_q;
      if ((state_q == IDLE) && req_valid) begin
         if (ctx_hit && ent_hit) begin
            if (hits_q != '1) hits_d = hits_q + 32'd1;
         end else begin
            if (misses_q != '1) misses_d = misses_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end

   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;
`endif

endmodule
